// File: rtl/viterbi_sched.sv
// viterbi_sched: runs one shared viterbi_pe over all states per observation, then backtracks the path.
// Latency: per step 1 + I*(1+PE_LAT) + 1 cycles plus observation wait; trace emits one element per accepted cycle.
// Backpressure: obs_ready only while waiting for a symbol; path_state/path_valid hold while path_ready is low.
// Ports: start/t_len begin a sequence; obs_* symbol input; pi/a_col/b_* model store lookups;
//        pe_* drive/receive the PE; path_* decoded states (time T-1 down to 0); busy/done status.
module viterbi_sched #(
   parameter  int I      = 3,
   parameter  int W      = 20,
   parameter  int NOBS   = 4,
   parameter  int MAX_T  = 16,
   parameter  int PE_LAT = 1,
   localparam int SW     = $clog2(I),
   localparam int OW     = $clog2(NOBS),
   localparam int TW     = $clog2(MAX_T + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [TW-1:0]   t_len,
   input  logic            obs_valid,
   input  logic [OW-1:0]   obs_in,
   output logic            obs_ready,
   input  logic [I*W-1:0]  pi_data,
   output logic [SW-1:0]   a_col_sel,
   input  logic [I*W-1:0]  a_col_data,
   output logic [SW-1:0]   b_state,
   output logic [OW-1:0]   b_obs,
   input  logic [W-1:0]    b_data,
   output logic [OW-1:0]   pe_obs,
   output logic [I*W-1:0]  pe_delta_prev,
   output logic [I*W-1:0]  pe_logA_col,
   output logic [W-1:0]    pe_logB_emit,
   input  logic [W-1:0]    pe_delta_out,
   input  logic [SW-1:0]   pe_psi_out,
   output logic            path_valid,
   output logic [SW-1:0]   path_state,
   output logic            path_last,
   input  logic            path_ready,
   output logic            busy,
   output logic            done
);

   localparam int RW = $clog2(MAX_T);                     // psi row index width
   localparam int CW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1; // PE wait counter width

   typedef enum logic [3:0] {
      S_IDLE, S_INIT_OBS, S_INIT, S_STEP_OBS, S_ISSUE,
      S_WAIT, S_SWAP, S_FINAL, S_TRACE, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        t_q, t_d;
   logic [TW-1:0]        tlen_q, tlen_d;
   logic [SW-1:0]        j_q, j_d;
   logic [SW-1:0]        s_q, s_d;
   logic [CW-1:0]        wcnt_q, wcnt_d;
   logic [OW-1:0]        cur_obs_q, cur_obs_d;
   logic signed [W-1:0]  delta_cur_q [I];
   logic signed [W-1:0]  delta_cur_d [I];
   logic signed [W-1:0]  delta_nxt_q [I];
   logic signed [W-1:0]  delta_nxt_d [I];
   logic [SW-1:0]        psi_q [MAX_T][I];
   logic [SW-1:0]        psi_d [MAX_T][I];

   logic signed [W-1:0]  pi_arr [I];
   logic [SW-1:0]        best_idx;
   logic signed [W-1:0]  best_val;

   function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W:0] sum;
      sum = {a[W-1], a} + {b[W-1], b};
      // Overflow shows up as the two top bits disagreeing.
      if (sum[W] != sum[W-1])
         return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return sum[W-1:0];
   endfunction

   always_comb begin
      for (int k = 0; k < I; k++)
         pi_arr[k] = $signed(pi_data[k*W +: W]);
   end

   // Final-state argmax; strict compare keeps the lowest index on ties, matching the PE.
   always_comb begin
      best_idx = '0;
      best_val = delta_cur_q[0];
      for (int k = 1; k < I; k++) begin
         if (delta_cur_q[k] > best_val) begin
            best_val = delta_cur_q[k];
            best_idx = SW'(k);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      t_d           = t_q;
      tlen_d        = tlen_q;
      j_d           = j_q;
      s_d           = s_q;
      wcnt_d        = wcnt_q;
      cur_obs_d     = cur_obs_q;
      delta_cur_d   = delta_cur_q;
      delta_nxt_d   = delta_nxt_q;
      psi_d         = psi_q;
      obs_ready     = 1'b0;
      a_col_sel     = '0;
      b_state       = '0;
      b_obs         = '0;
      pe_obs        = '0;
      pe_delta_prev = '0;
      pe_logA_col   = '0;
      pe_logB_emit  = '0;
      path_valid    = 1'b0;
      path_state    = '0;
      path_last     = 1'b0;
      done          = 1'b0;
      busy          = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tlen_d  = (t_len > TW'(MAX_T)) ? TW'(MAX_T) : t_len;
               t_d     = '0;
               j_d     = '0;
               state_d = (t_len == '0) ? S_DONE : S_INIT_OBS;
            end
         end
         S_INIT_OBS, S_STEP_OBS: begin
            obs_ready = 1'b1;
            if (obs_valid) begin
               cur_obs_d = obs_in;
               j_d       = '0;
               state_d   = (state_q == S_INIT_OBS) ? S_INIT : S_ISSUE;
            end
         end
         S_INIT: begin
            b_state = j_q;
            b_obs   = cur_obs_q;
            delta_cur_d[j_q] = sat_add(pi_arr[j_q], $signed(b_data));
            if (j_q == SW'(I - 1)) begin
               t_d     = TW'(1);
               state_d = (tlen_q == TW'(1)) ? S_FINAL : S_STEP_OBS;
            end else begin
               j_d = j_q + SW'(1);
            end
         end
         S_ISSUE, S_WAIT: begin
            // PE inputs stay constant from ISSUE until the capture at the end of WAIT.
            a_col_sel    = j_q;
            b_state      = j_q;
            b_obs        = cur_obs_q;
            pe_obs       = cur_obs_q;
            pe_logA_col  = a_col_data;
            pe_logB_emit = b_data;
            for (int k = 0; k < I; k++)
               pe_delta_prev[k*W +: W] = delta_cur_q[k];
            if (state_q == S_ISSUE) begin
               wcnt_d  = '0;
               state_d = S_WAIT;
            end else if (wcnt_q == CW'(PE_LAT - 1)) begin
               delta_nxt_d[j_q]           = $signed(pe_delta_out);
               psi_d[t_q[RW-1:0]][j_q]    = pe_psi_out;
               if (j_q == SW'(I - 1)) begin
                  state_d = S_SWAP;
               end else begin
                  j_d     = j_q + SW'(1);
                  state_d = S_ISSUE;
               end
            end else begin
               wcnt_d = wcnt_q + CW'(1);
            end
         end
         S_SWAP: begin
            delta_cur_d = delta_nxt_q;
            t_d         = t_q + TW'(1);
            state_d     = ((t_q + TW'(1)) == tlen_q) ? S_FINAL : S_STEP_OBS;
         end
         S_FINAL: begin
            s_d     = best_idx;
            t_d     = tlen_q - TW'(1);
            state_d = S_TRACE;
         end
         S_TRACE: begin
            path_valid = 1'b1;
            path_state = s_q;
            path_last  = (t_q == '0);
            if (path_ready) begin
               if (t_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  s_d = psi_q[t_q[RW-1:0]][s_q];
                  t_d = t_q - TW'(1);
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         t_q       <= '0;
         tlen_q    <= '0;
         j_q       <= '0;
         s_q       <= '0;
         wcnt_q    <= '0;
         cur_obs_q <= '0;
         for (int k = 0; k < I; k++) begin
            delta_cur_q[k] <= '0;
            delta_nxt_q[k] <= '0;
         end
         for (int r = 0; r < MAX_T; r++)
            for (int k = 0; k < I; k++)
               psi_q[r][k] <= '0;
      end else begin
         state_q     <= state_d;
         t_q         <= t_d;
         tlen_q      <= tlen_d;
         j_q         <= j_d;
         s_q         <= s_d;
         wcnt_q      <= wcnt_d;
         cur_obs_q   <= cur_obs_d;
         delta_cur_q <= delta_cur_d;
         delta_nxt_q <= delta_nxt_d;
         psi_q       <= psi_d;
      end
   end

endmodule

// File: tb/tb_viterbi_sched.sv
module tb_viterbi_sched;
   localparam int I = 3, W = 20, NOBS = 4, MAX_T = 16, PE_LAT = 1;
   localparam int SW = 2, OW = 2, TW = 5;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            start = 1'b0;
   logic [TW-1:0]   t_len = '0;
   logic            obs_valid = 1'b0;
   logic [OW-1:0]   obs_in = '0;
   logic            obs_ready;
   logic [I*W-1:0]  pi_data, a_col_data;
   logic [SW-1:0]   a_col_sel, b_state;
   logic [OW-1:0]   b_obs, pe_obs;
   logic [W-1:0]    b_data;
   logic [I*W-1:0]  pe_delta_prev, pe_logA_col;
   logic [W-1:0]    pe_logB_emit;
   logic [W-1:0]    pe_delta_out = '0;
   logic [SW-1:0]   pe_psi_out = '0;
   logic            path_valid, path_last, busy, done;
   logic [SW-1:0]   path_state;
   logic            path_ready = 1'b1;

   viterbi_sched #(.I(I), .W(W), .NOBS(NOBS), .MAX_T(MAX_T), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .t_len(t_len),
      .obs_valid(obs_valid), .obs_in(obs_in), .obs_ready(obs_ready),
      .pi_data(pi_data), .a_col_sel(a_col_sel), .a_col_data(a_col_data),
      .b_state(b_state), .b_obs(b_obs), .b_data(b_data),
      .pe_obs(pe_obs), .pe_delta_prev(pe_delta_prev), .pe_logA_col(pe_logA_col),
      .pe_logB_emit(pe_logB_emit), .pe_delta_out(pe_delta_out), .pe_psi_out(pe_psi_out),
      .path_valid(path_valid), .path_state(path_state), .path_last(path_last),
      .path_ready(path_ready), .busy(busy), .done(done)
   );

   // Model stores: la[k][j] = log P(k -> j), lb[j][o] = log P(o | j)
   int pi_t [I];
   int la   [I][I];
   int lb   [I][NOBS];
   int obs_seq [MAX_T];

   typedef struct { int st; bit last; } exp_t;
   exp_t exp_q [$];

   int total = 0;
   int bad = 0;
   int accepted = 0;
   int stall_left = 0;
   bit seq_end = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   always_comb begin
      for (int k = 0; k < I; k++) begin
         pi_data[k*W +: W]    = W'(pi_t[k]);
         a_col_data[k*W +: W] = (int'(a_col_sel) < I) ? W'(la[k][a_col_sel]) : '0;
      end
      b_data = (int'(b_state) < I) ? W'(lb[b_state][b_obs]) : '0;
   end

   // Behavioural PE with one cycle of latency
   always @(posedge clk) begin : pe_model
      int best, v, bi;
      best = sx(pe_delta_prev[0 +: W]) + sx(pe_logA_col[0 +: W]);
      bi = 0;
      for (int k = 1; k < I; k++) begin
         v = sx(pe_delta_prev[k*W +: W]) + sx(pe_logA_col[k*W +: W]);
         if (v > best) begin best = v; bi = k; end
      end
      pe_delta_out <= W'(sat(best + sx(pe_logB_emit)));
      pe_psi_out   <= SW'(bi);
   end

   // Golden Viterbi; pushes the path in emission order (time T-1 first)
   function automatic void build_expected(input int T);
      int d  [MAX_T][I];
      int ps [MAX_T][I];
      int s, best, bi, v;
      for (int j = 0; j < I; j++) d[0][j] = sat(pi_t[j] + lb[j][obs_seq[0]]);
      for (int t = 1; t < T; t++) begin
         for (int j = 0; j < I; j++) begin
            best = d[t-1][0] + la[0][j];
            bi = 0;
            for (int k = 1; k < I; k++) begin
               v = d[t-1][k] + la[k][j];
               if (v > best) begin best = v; bi = k; end
            end
            d[t][j]  = sat(best + lb[j][obs_seq[t]]);
            ps[t][j] = bi;
         end
      end
      s = 0;
      for (int j = 1; j < I; j++) if (d[T-1][j] > d[T-1][s]) s = j;
      for (int t = T - 1; t >= 0; t--) begin
         exp_q.push_back('{st: s, last: (t == 0)});
         if (t > 0) s = ps[t][s];
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n && path_valid) begin
         if (exp_q.size() == 0) begin
            chk("extra_elem", 1, 0);
         end else begin
            chk("path_state", path_state, exp_q[0].st);
            chk("path_last", path_last, exp_q[0].last);
            if (path_ready) begin
               void'(exp_q.pop_front());
               accepted++;
            end
         end
      end
   end

   task automatic clear_hmm();
      for (int k = 0; k < I; k++) begin
         pi_t[k] = 0;
         for (int j = 0; j < I; j++) la[k][j] = 0;
         for (int o = 0; o < NOBS; o++) lb[k][o] = 0;
      end
   endtask

   task automatic random_hmm();
      for (int k = 0; k < I; k++) begin
         pi_t[k] = -int'($urandom_range(0, 40));
         for (int j = 0; j < I; j++) la[k][j] = -int'($urandom_range(0, 60));
         for (int o = 0; o < NOBS; o++) lb[k][o] = -int'($urandom_range(0, 60));
      end
      for (int t = 0; t < MAX_T; t++) obs_seq[t] = int'($urandom_range(0, NOBS - 1));
   endtask

   task automatic pulse_start(input int tlen);
      @(posedge clk); #1;
      start = 1'b1;
      t_len = TW'(tlen);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // poke raises start while the controller is busy; it must be ignored
   task automatic feed_obs(input int v, input int gap, input bit poke);
      int w;
      w = 0;
      if (gap > 0) begin
         obs_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      obs_valid = 1'b1;
      obs_in = OW'(v);
      if (poke) begin start = 1'b1; t_len = TW'(0); end
      do begin @(negedge clk); w++; end while (!obs_ready && w < 500);
      if (!obs_ready) chk("obs_handshake", 0, 1);
      @(posedge clk); #1;
      obs_valid = 1'b0;
      if (poke) start = 1'b0;
   endtask

   task automatic run_seq(input int tlen, input int gap, input bit stall);
      int T, nexp;
      T = (tlen > MAX_T) ? MAX_T : tlen;
      exp_q.delete();
      if (T > 0) build_expected(T);
      nexp = exp_q.size();
      accepted = 0;
      seq_end = 1'b0;
      stall_left = stall ? 5 : 0;
      pulse_start(tlen);
      fork
         begin
            for (int i = 0; i < T; i++) feed_obs(obs_seq[i], gap, i == 1);
         end
         begin
            while (!seq_end) begin
               @(posedge clk); #1;
               if (stall_left > 0 && accepted == 2) begin
                  path_ready = 1'b0;
                  stall_left--;
               end else begin
                  path_ready = 1'b1;
               end
            end
         end
         begin
            int cyc;
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!done && cyc < 3000);
            chk("done_seen", done, 1);
            if (tlen == 0) chk("t0_done_lat", cyc, 1);
            start = 1'b1;             // must be ignored in the DONE cycle
            t_len = TW'(3);
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("idle_after_done", busy, 0);
            chk("path_count", accepted, nexp);
            chk("queue_empty", exp_q.size(), 0);
            seq_end = 1'b1;
         end
      join
   endtask

   task automatic set_pe_capture_hmm();
      clear_hmm();
      pi_t[0] = 10; pi_t[1] = 20; pi_t[2] = 15;
      la[0][0] = 1; la[1][0] = 1; la[2][0] = 1;
      la[0][1] = 5; la[1][1] = 3; la[2][1] = 2;
      lb[1][1] = 4;
      obs_seq[0] = 0; obs_seq[1] = 1;
   endtask

   task automatic reset_mid();
      logic [I*W-1:0] e;
      set_pe_capture_hmm();
      exp_q.delete();
      pulse_start(3);
      feed_obs(0, 0, 1'b0);
      feed_obs(1, 0, 1'b0);
      // now in ISSUE for target state 0
      e = {W'(15), W'(20), W'(10)};
      chk("issue_delta_prev", pe_delta_prev, e);
      chk("issue0_col_sel", a_col_sel, 0);
      chk("issue0_pe_obs", pe_obs, 1);
      chk("busy_in_issue", busy, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      // ISSUE for target state 1
      e = {W'(2), W'(3), W'(5)};
      chk("issue1_col_sel", a_col_sel, 1);
      chk("issue1_logA_col", pe_logA_col, e);
      chk("issue1_logB", pe_logB_emit, 4);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_obs_ready", obs_ready, 0);
      chk("rst_path_valid", path_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_col_sel", a_col_sel, 0);
      chk("rst_b_obs", b_obs, 0);
      chk("rst_pe_obs", pe_obs, 0);
      chk("rst_delta_prev", pe_delta_prev, 0);
      chk("rst_logA_col", pe_logA_col, 0);
      chk("rst_logB", pe_logB_emit, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_hmm();
      for (int t = 0; t < MAX_T; t++) obs_seq[t] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_path_valid", path_valid, 0);
      chk("reset_obs_ready", obs_ready, 0);
      chk("reset_delta_prev", pe_delta_prev, 0);
      rst_n = 1'b1;

      // T=1, single element state 1
      clear_hmm();
      lb[0][2] = 1; lb[1][2] = 7; lb[2][2] = 3;
      obs_seq[0] = 2;
      run_seq(1, 0, 1'b0);

      // Init saturation: both states clamp to MAXV, tie resolves to state 0
      clear_hmm();
      pi_t[0] = MAXV - 7; pi_t[1] = MAXV;
      lb[0][3] = 20; lb[1][3] = 50;
      obs_seq[0] = 3;
      run_seq(1, 0, 1'b0);

      // One PE step where target 1 wins with 27 via predecessor 1
      set_pe_capture_hmm();
      run_seq(2, 0, 1'b0);

      // Full T=4 decodes: plain, observation gaps, sink stall
      random_hmm();
      run_seq(4, 0, 1'b0);
      random_hmm();
      run_seq(4, 3, 1'b0);
      random_hmm();
      run_seq(4, 3, 1'b1);

      // Empty sequence and over-length clamp
      run_seq(0, 0, 1'b0);
      random_hmm();
      run_seq(20, 0, 1'b1);

      // Abort mid-sequence, then a clean decode
      reset_mid();
      set_pe_capture_hmm();
      run_seq(2, 0, 1'b0);
      random_hmm();
      run_seq(4, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
